// File: rtl/otter_mem2_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : otter_mem2_arbiter
//  Purpose  : Owner selection and sequencing for OTTER memory port 2 (data
//             port). Shares the port between the serial programmer, the CPU
//             load/store path and a DMA requester. Holds the CPU and DMA off
//             while a programming session is active and for a drain interval
//             afterwards. Bounds DMA starvation behind the CPU.
//  Ports    : CLK, RESET (async, active high)
//             PROG_ACTIVE/PROG_WE/PROG_ADDR/PROG_DATA  - programmer writes
//             CPU_REQ/WE/ADDR/DIN/SIZE/SIGN -> CPU_GNT - CPU data access
//             DMA_REQ/WE/ADDR/DIN -> DMA_GNT, DMA_RVALID - DMA word access
//             MEM_ADDR2/DIN2/WE2/RD2/SIZE/SIGN           - memory / IOBUS side
//  Revision : 1.0 - initial release
// ============================================================================
module otter_mem2_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        PROG_ACTIVE,
   input  logic        PROG_WE,
   input  logic [31:0] PROG_ADDR,
   input  logic [31:0] PROG_DATA,
   input  logic        CPU_REQ,
   input  logic        CPU_WE,
   input  logic [31:0] CPU_ADDR,
   input  logic [31:0] CPU_DIN,
   input  logic [1:0]  CPU_SIZE,
   input  logic        CPU_SIGN,
   output logic        CPU_GNT,
   input  logic        DMA_REQ,
   input  logic        DMA_WE,
   input  logic [31:0] DMA_ADDR,
   input  logic [31:0] DMA_DIN,
   output logic        DMA_GNT,
   output logic        DMA_RVALID,
   output logic [31:0] MEM_ADDR2,
   output logic [31:0] MEM_DIN2,
   output logic        MEM_WE2,
   output logic        MEM_RD2,
   output logic [1:0]  MEM_SIZE,
   output logic        MEM_SIGN
);

   localparam int c_SW = $clog2(STARVE_LIMIT + 1);
   localparam int c_DW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
   localparam logic [c_DW-1:0] c_DRAIN_LOAD = c_DW'(DRAIN_CYCLES);
   localparam logic [c_DW-1:0] c_DRAIN_ONE  = c_DW'(1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_LOCK  = 2'd1,
      ST_DRAIN = 2'd2
   } mode_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_PROG = 2'd1,
      OWN_CPU  = 2'd2,
      OWN_DMA  = 2'd3
   } owner_t;

   mode_t            r_mode, w_mode_nxt;
   logic [c_DW-1:0]  r_drain_cnt, w_drain_nxt;
   logic [c_SW-1:0]  r_starve_cnt;
   logic             r_dma_rvalid;
   owner_t           w_owner;
   logic             w_prog_any;
   logic             w_enter_lock;
   logic             w_we, w_rd;

   assign w_prog_any   = PROG_ACTIVE | PROG_WE;
   assign w_enter_lock = (w_mode_nxt == ST_LOCK) && (r_mode != ST_LOCK);

   // ---------------------------------------------------------------- mode FSM
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_mode      <= ST_RUN;
         r_drain_cnt <= '0;
      end else begin
         r_mode      <= w_mode_nxt;
         r_drain_cnt <= w_drain_nxt;
      end
   end

   always_comb begin
      w_mode_nxt  = r_mode;
      w_drain_nxt = r_drain_cnt;
      case (r_mode)
         ST_RUN: begin
            if (w_prog_any) w_mode_nxt = ST_LOCK;
         end
         ST_LOCK: begin
            if (!w_prog_any) begin
               w_mode_nxt  = ST_DRAIN;
               w_drain_nxt = c_DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            // Renewed programmer activity aborts the drain; the count is
            // reloaded when LOCK is next left.
            if (w_prog_any) begin
               w_mode_nxt = ST_LOCK;
            end else begin
               w_drain_nxt = r_drain_cnt - 1'b1;
               if (r_drain_cnt <= c_DRAIN_ONE) w_mode_nxt = ST_RUN;
            end
         end
         default: begin
            w_mode_nxt  = ST_RUN;
            w_drain_nxt = '0;
         end
      endcase
   end

   // ------------------------------------------------------- owner selection
   always_comb begin
      w_owner = OWN_NONE;
      if (PROG_WE) begin
         w_owner = OWN_PROG;
      end else if (r_mode == ST_RUN) begin
         // A DMA that has waited STARVE_LIMIT cycles jumps ahead of the CPU.
         if (DMA_REQ && (r_starve_cnt == c_STARVE_MAX)) w_owner = OWN_DMA;
         else if (CPU_REQ)                              w_owner = OWN_CPU;
         else if (DMA_REQ)                              w_owner = OWN_DMA;
      end
   end

   // ----------------------------------------------------------- port drive
   always_comb begin
      w_we      = 1'b0;
      w_rd      = 1'b0;
      MEM_ADDR2 = CPU_ADDR;
      MEM_DIN2  = CPU_DIN;
      MEM_SIZE  = CPU_SIZE;
      MEM_SIGN  = CPU_SIGN;
      case (w_owner)
         OWN_PROG: begin
            MEM_ADDR2 = PROG_ADDR;
            MEM_DIN2  = PROG_DATA;
            MEM_SIZE  = 2'b10;
            MEM_SIGN  = 1'b0;
            w_we      = 1'b1;
         end
         OWN_CPU: begin
            w_we = CPU_WE;
            w_rd = !CPU_WE;
         end
         OWN_DMA: begin
            MEM_ADDR2 = DMA_ADDR;
            MEM_DIN2  = DMA_DIN;
            MEM_SIZE  = 2'b10;
            MEM_SIGN  = 1'b0;
            w_we      = DMA_WE;
            w_rd      = !DMA_WE;
         end
         default: ;
      endcase
   end

   // Strobes are gated by RESET directly so they drop without waiting for
   // a clock edge.
   assign MEM_WE2    = w_we & ~RESET;
   assign MEM_RD2    = w_rd & ~RESET;
   assign CPU_GNT    = (w_owner == OWN_CPU) & ~RESET;
   assign DMA_GNT    = (w_owner == OWN_DMA) & ~RESET;
   assign DMA_RVALID = r_dma_rvalid;

   // ------------------------------------------------- starvation counter
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_starve_cnt <= '0;
      end else if ((w_owner == OWN_DMA) || !DMA_REQ || w_enter_lock) begin
         r_starve_cnt <= '0;
      end else if ((r_mode == ST_RUN) && (r_starve_cnt != c_STARVE_MAX)) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   // Memory read data for a DMA read is on MEM_DOUT2 the cycle after grant.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_dma_rvalid <= 1'b0;
      else       r_dma_rvalid <= (w_owner == OWN_DMA) && !DMA_WE;
   end

endmodule
`default_nettype wire

// File: tb/tb_otter_mem2_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_otter_mem2_arbiter
//  Purpose  : Self-checking bench for otter_mem2_arbiter (STARVE_LIMIT=4,
//             DRAIN_CYCLES=4): directed scenarios plus a randomized run
//             against a behavioural model of lockout, drain and starvation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_otter_mem2_arbiter;

   localparam int LIMIT = 4;
   localparam int DRAIN = 4;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        PROG_ACTIVE, PROG_WE;
   logic [31:0] PROG_ADDR, PROG_DATA;
   logic        CPU_REQ, CPU_WE, CPU_SIGN;
   logic [31:0] CPU_ADDR, CPU_DIN;
   logic [1:0]  CPU_SIZE;
   logic        CPU_GNT;
   logic        DMA_REQ, DMA_WE;
   logic [31:0] DMA_ADDR, DMA_DIN;
   logic        DMA_GNT, DMA_RVALID;
   logic [31:0] MEM_ADDR2, MEM_DIN2;
   logic        MEM_WE2, MEM_RD2, MEM_SIGN;
   logic [1:0]  MEM_SIZE;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   otter_mem2_arbiter #(.STARVE_LIMIT(LIMIT), .DRAIN_CYCLES(DRAIN)) dut (
      .CLK(CLK), .RESET(RESET),
      .PROG_ACTIVE(PROG_ACTIVE), .PROG_WE(PROG_WE),
      .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
      .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR),
      .CPU_DIN(CPU_DIN), .CPU_SIZE(CPU_SIZE), .CPU_SIGN(CPU_SIGN),
      .CPU_GNT(CPU_GNT),
      .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_ADDR(DMA_ADDR),
      .DMA_DIN(DMA_DIN), .DMA_GNT(DMA_GNT), .DMA_RVALID(DMA_RVALID),
      .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WE2(MEM_WE2),
      .MEM_RD2(MEM_RD2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN)
   );

   // ------------------------------------------------ behavioural model
   // in_session: programmer holds the port; drain_left: lockout cycles still
   // owed after the session; denied: consecutive cycles the DMA was refused.
   bit          m_session;
   int          m_drain_left;
   int          m_denied;
   bit          m_rv;
   int          e_owner;   // 0 none, 1 prog, 2 cpu, 3 dma
   logic [31:0] e_addr, e_din;
   logic        e_we, e_rd, e_sign, e_cgnt, e_dgnt;
   logic [1:0]  e_size;

   task automatic model_reset();
      m_session = 0; m_drain_left = 0; m_denied = 0; m_rv = 0;
   endtask

   task automatic model_eval();
      bit running;
      running = !m_session && (m_drain_left == 0);
      if (PROG_WE)                              e_owner = 1;
      else if (!running)                        e_owner = 0;
      else if (DMA_REQ && m_denied >= LIMIT)    e_owner = 3;
      else if (CPU_REQ)                         e_owner = 2;
      else if (DMA_REQ)                         e_owner = 3;
      else                                      e_owner = 0;
      e_addr = CPU_ADDR; e_din = CPU_DIN; e_size = CPU_SIZE; e_sign = CPU_SIGN;
      e_we = 0; e_rd = 0;
      if (e_owner == 1) begin
         e_addr = PROG_ADDR; e_din = PROG_DATA; e_size = 2'b10; e_sign = 0; e_we = 1;
      end else if (e_owner == 2) begin
         e_we = CPU_WE; e_rd = !CPU_WE;
      end else if (e_owner == 3) begin
         e_addr = DMA_ADDR; e_din = DMA_DIN; e_size = 2'b10; e_sign = 0;
         e_we = DMA_WE; e_rd = !DMA_WE;
      end
      e_cgnt = (e_owner == 2);
      e_dgnt = (e_owner == 3);
   endtask

   task automatic model_tick();
      bit prog_any, running;
      prog_any = PROG_ACTIVE || PROG_WE;
      running  = !m_session && (m_drain_left == 0);
      if (e_dgnt || !DMA_REQ || (prog_any && !m_session)) m_denied = 0;
      else if (running && m_denied < LIMIT)                m_denied++;
      if (prog_any) begin
         m_session = 1; m_drain_left = 0;
      end else if (m_session) begin
         m_session = 0; m_drain_left = DRAIN;
      end else if (m_drain_left > 0) begin
         m_drain_left--;
      end
      m_rv = e_dgnt && !DMA_WE;
   endtask

   // --------------------------------------------------- stimulus helpers
   task automatic idle();
      PROG_ACTIVE = 0; PROG_WE = 0; PROG_ADDR = 0; PROG_DATA = 0;
      CPU_REQ = 0; CPU_WE = 0; CPU_ADDR = 0; CPU_DIN = 0; CPU_SIZE = 2'b10; CPU_SIGN = 0;
      DMA_REQ = 0; DMA_WE = 0; DMA_ADDR = 0; DMA_DIN = 0;
   endtask

   // Leaves time just after a negedge, ready to drive the next cycle.
   task automatic sync_reset();
      @(negedge CLK);
      RESET = 1;
      @(negedge CLK);
      RESET = 0;
   endtask

   // ------------------------------------------------------------- tests
   task automatic test_reset();
      idle();
      RESET = 1;
      CPU_REQ = 1; DMA_REQ = 1;
      @(negedge CLK); #1;
      total++;
      if ({CPU_GNT, DMA_GNT, MEM_WE2, MEM_RD2, DMA_RVALID} !== 5'b0) begin
         bad++; $display("FAIL reset_strobes: got %b want 00000",
                         {CPU_GNT, DMA_GNT, MEM_WE2, MEM_RD2, DMA_RVALID});
      end
      @(negedge CLK);
      RESET = 0;
      #1;
      total++;
      if ({CPU_GNT, DMA_GNT} !== 2'b10) begin
         bad++; $display("FAIL reset_release_gnt: got %b want 10", {CPU_GNT, DMA_GNT});
      end
      @(negedge CLK);
      idle();
   endtask

   task automatic test_cpu_alone();
      idle();
      CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 32'h100; CPU_SIZE = 2'b01; CPU_SIGN = 1;
      #1;
      total++;
      if ({CPU_GNT, DMA_GNT, MEM_RD2, MEM_WE2} !== 4'b1010 || MEM_ADDR2 !== 32'h100
          || MEM_SIZE !== 2'b01 || MEM_SIGN !== 1'b1) begin
         bad++; $display("FAIL cpu_read: gnt/rd/we=%b addr=%h size=%b want 1010 00000100 01",
                         {CPU_GNT, DMA_GNT, MEM_RD2, MEM_WE2}, MEM_ADDR2, MEM_SIZE);
      end
      @(negedge CLK);
      CPU_WE = 1; CPU_DIN = 32'hCAFE0001; CPU_ADDR = 32'h104;
      #1;
      total++;
      if ({CPU_GNT, MEM_RD2, MEM_WE2} !== 3'b101 || MEM_DIN2 !== 32'hCAFE0001) begin
         bad++; $display("FAIL cpu_write: gnt/rd/we=%b din=%h want 101 cafe0001",
                         {CPU_GNT, MEM_RD2, MEM_WE2}, MEM_DIN2);
      end
      @(negedge CLK);
      CPU_REQ = 0; CPU_ADDR = 32'h208; CPU_DIN = 32'h77; CPU_SIZE = 2'b00; CPU_SIGN = 1;
      #1;
      total++;
      if ({CPU_GNT, DMA_GNT, MEM_RD2, MEM_WE2} !== 4'b0 || MEM_ADDR2 !== 32'h208
          || MEM_DIN2 !== 32'h77 || MEM_SIZE !== 2'b00 || MEM_SIGN !== 1'b1) begin
         bad++; $display("FAIL no_owner: strobes=%b addr=%h din=%h size=%b sign=%b want 0 208 77 00 1",
                         {CPU_GNT, DMA_GNT, MEM_RD2, MEM_WE2}, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN);
      end
      @(negedge CLK);
      idle();
   endtask

   task automatic test_contention();
      idle();
      @(negedge CLK);
      CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 32'h300; CPU_SIZE = 2'b00;
      DMA_REQ = 1; DMA_WE = 0; DMA_ADDR = 32'h200;
      for (int i = 0; i < 6; i++) begin
         logic exp_c, exp_d, exp_rv;
         exp_d  = (i == LIMIT);
         exp_c  = !exp_d;
         exp_rv = (i == LIMIT + 1);
         #1;
         total++;
         if ({CPU_GNT, DMA_GNT, DMA_RVALID} !== {exp_c, exp_d, exp_rv}) begin
            bad++; $display("FAIL contention_c%0d: cgnt/dgnt/rv=%b want %b", i,
                            {CPU_GNT, DMA_GNT, DMA_RVALID}, {exp_c, exp_d, exp_rv});
         end
         if (exp_d) begin
            total++;
            if (MEM_ADDR2 !== 32'h200 || MEM_SIZE !== 2'b10 || MEM_RD2 !== 1'b1) begin
               bad++; $display("FAIL contention_dma_drive: addr=%h size=%b rd=%b want 200 10 1",
                               MEM_ADDR2, MEM_SIZE, MEM_RD2);
            end
         end
         @(negedge CLK);
      end
      idle();
      @(negedge CLK);
   endtask

   task automatic test_prog_session();
      idle();
      PROG_ACTIVE = 1;
      @(negedge CLK);
      PROG_WE = 1; PROG_ADDR = 32'h0; PROG_DATA = 32'hDEADBEEF; CPU_REQ = 1; CPU_SIZE = 2'b00;
      #1;
      total++;
      if ({MEM_WE2, MEM_RD2, CPU_GNT, DMA_GNT} !== 4'b1000 || MEM_SIZE !== 2'b10
          || MEM_DIN2 !== 32'hDEADBEEF || MEM_ADDR2 !== 32'h0) begin
         bad++; $display("FAIL prog_write: we/rd/cg/dg=%b size=%b din=%h addr=%h want 1000 10 deadbeef 0",
                         {MEM_WE2, MEM_RD2, CPU_GNT, DMA_GNT}, MEM_SIZE, MEM_DIN2, MEM_ADDR2);
      end
      @(negedge CLK);
      PROG_WE = 0;
      #1;
      total++;
      if ({CPU_GNT, MEM_WE2, MEM_RD2} !== 3'b000) begin
         bad++; $display("FAIL prog_lock_idle: cg/we/rd=%b want 000", {CPU_GNT, MEM_WE2, MEM_RD2});
      end
      @(negedge CLK);
      PROG_ACTIVE = 0;   // last LOCK cycle
      for (int j = 0; j <= DRAIN + 1; j++) begin
         logic exp_c;
         exp_c = (j == DRAIN + 1);
         #1;
         total++;
         if (CPU_GNT !== exp_c) begin
            bad++; $display("FAIL drain_c%0d: cpu_gnt=%b want %b", j, CPU_GNT, exp_c);
         end
         @(negedge CLK);
      end
      idle();
   endtask

   task automatic test_prog_collision();
      idle();
      CPU_REQ = 1; CPU_WE = 1; CPU_ADDR = 32'h11000000; CPU_DIN = 32'h55;
      PROG_WE = 1; PROG_ADDR = 32'h40; PROG_DATA = 32'h1234;
      #1;
      total++;
      if ({CPU_GNT, DMA_GNT, MEM_WE2} !== 3'b001 || MEM_ADDR2 !== 32'h40 || MEM_DIN2 !== 32'h1234) begin
         bad++; $display("FAIL collision: cg/dg/we=%b addr=%h din=%h want 001 40 1234",
                         {CPU_GNT, DMA_GNT, MEM_WE2}, MEM_ADDR2, MEM_DIN2);
      end
      @(negedge CLK);
      PROG_WE = 0;
      // One LOCK cycle, DRAIN cycles of lockout, then the CPU store goes.
      for (int j = 0; j <= DRAIN + 1; j++) begin
         logic exp_c;
         exp_c = (j == DRAIN + 1);
         #1;
         total++;
         if (CPU_GNT !== exp_c) begin
            bad++; $display("FAIL collision_lock_c%0d: cpu_gnt=%b want %b", j, CPU_GNT, exp_c);
         end
         @(negedge CLK);
      end
      idle();
   endtask

   task automatic test_drain_reassert();
      // Pattern of PROG_ACTIVE per cycle and the CPU_GNT it must produce.
      logic [10:0] pa_seq, gnt_seq;
      pa_seq  = 11'b00000001001;   // bit i = cycle i
      gnt_seq = 11'b11000000001;
      idle();
      CPU_REQ = 1;
      for (int i = 0; i < 11; i++) begin
         PROG_ACTIVE = pa_seq[i];
         #1;
         total++;
         if (CPU_GNT !== gnt_seq[i]) begin
            bad++; $display("FAIL reassert_c%0d: cpu_gnt=%b want %b", i, CPU_GNT, gnt_seq[i]);
         end
         @(negedge CLK);
      end
      idle();
   endtask

   task automatic test_async_reset();
      idle();
      DMA_REQ = 1; DMA_WE = 0; DMA_ADDR = 32'h80; PROG_ACTIVE = 1;
      #1;
      total++;
      if (DMA_GNT !== 1'b1) begin
         bad++; $display("FAIL areset_dma_gnt: got %b want 1", DMA_GNT);
      end
      @(negedge CLK);
      DMA_REQ = 0; PROG_WE = 1; PROG_ADDR = 32'h8; PROG_DATA = 32'h9;
      #1;
      total++;
      if ({DMA_RVALID, MEM_WE2} !== 2'b11) begin
         bad++; $display("FAIL areset_pre: rv/we=%b want 11", {DMA_RVALID, MEM_WE2});
      end
      RESET = 1;
      #1;
      total++;
      if ({DMA_RVALID, MEM_WE2, MEM_RD2} !== 3'b000) begin
         bad++; $display("FAIL areset_prog: rv/we/rd=%b want 000", {DMA_RVALID, MEM_WE2, MEM_RD2});
      end
      PROG_WE = 0; PROG_ACTIVE = 0; CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 32'h44;
      #1;
      total++;
      if ({CPU_GNT, DMA_GNT, MEM_RD2, DMA_RVALID} !== 4'b0000) begin
         bad++; $display("FAIL areset_hold: cg/dg/rd/rv=%b want 0000",
                         {CPU_GNT, DMA_GNT, MEM_RD2, DMA_RVALID});
      end
      RESET = 0;
      #1;
      total++;
      if ({CPU_GNT, MEM_RD2} !== 2'b11) begin
         bad++; $display("FAIL areset_release: cg/rd=%b want 11", {CPU_GNT, MEM_RD2});
      end
      @(negedge CLK); #1;
      total++;
      if (CPU_GNT !== 1'b1) begin
         bad++; $display("FAIL areset_first_cycle: cpu_gnt=%b want 1", CPU_GNT);
      end
      @(negedge CLK);
      idle();
   endtask

   task automatic test_random();
      bit cpu_pend, dma_pend;
      idle();
      sync_reset();
      model_reset();
      cpu_pend = 0; dma_pend = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 39) == 0) PROG_ACTIVE = ~PROG_ACTIVE;
         PROG_WE   = PROG_ACTIVE ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
         PROG_ADDR = $urandom; PROG_DATA = $urandom;
         if (!cpu_pend) begin
            cpu_pend = ($urandom_range(0, 3) != 0);
            CPU_WE = 1'($urandom_range(0, 1)); CPU_ADDR = $urandom; CPU_DIN = $urandom;
            CPU_SIZE = 2'($urandom_range(0, 2)); CPU_SIGN = 1'($urandom_range(0, 1));
         end
         if (!dma_pend) begin
            dma_pend = ($urandom_range(0, 2) == 0);
            DMA_WE = 1'($urandom_range(0, 1)); DMA_ADDR = $urandom; DMA_DIN = $urandom;
         end
         CPU_REQ = cpu_pend;
         DMA_REQ = dma_pend;
         #1;
         model_eval();
         total++;
         if ({CPU_GNT, DMA_GNT, MEM_WE2, MEM_RD2, DMA_RVALID} !== {e_cgnt, e_dgnt, e_we, e_rd, m_rv}) begin
            bad++; $display("FAIL rand_strobes c%0d: cg/dg/we/rd/rv=%b want %b", c,
                            {CPU_GNT, DMA_GNT, MEM_WE2, MEM_RD2, DMA_RVALID},
                            {e_cgnt, e_dgnt, e_we, e_rd, m_rv});
         end
         total++;
         if (MEM_ADDR2 !== e_addr || MEM_DIN2 !== e_din || MEM_SIZE !== e_size || MEM_SIGN !== e_sign) begin
            bad++; $display("FAIL rand_fields c%0d: addr=%h din=%h size=%b sign=%b want %h %h %b %b", c,
                            MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN, e_addr, e_din, e_size, e_sign);
         end
         if (e_cgnt) cpu_pend = 0;
         if (e_dgnt) dma_pend = 0;
         model_tick();
         @(negedge CLK);
      end
      idle();
   endtask

   initial begin
      idle();
      RESET = 1;
      test_reset();
      test_cpu_alone();
      test_contention();
      test_prog_session();
      test_prog_collision();
      test_drain_reassert();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
